// File: rtl/aes_noc_feeder.sv
// NOC16 host driver for the AES-CBC peripheral: streams round key, IV and plaintext
// beats onto the link, then reassembles the two-beat ciphertext response.
module aes_noc_feeder #(
  parameter int         KEY_WORDS      = 22,
  parameter logic [7:0] CMD_KEY        = 8'd0,
  parameter logic [7:0] CMD_IV         = 8'd1,
  parameter logic [7:0] CMD_PT         = 8'd2,
  parameter logic [7:0] CMD_RSP        = 8'hFF,
  parameter int         TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_wr_en,
  input  logic [4:0]   key_wr_addr,
  input  logic [63:0]  key_wr_data,
  input  logic         key_load,
  input  logic [127:0] iv_data,
  input  logic         iv_load,
  input  logic         pt_valid,
  output logic         pt_ready,
  input  logic [127:0] pt_data,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic [127:0] ct_data,
  output logic [63:0]  noc_tx_lo,
  output logic [7:0]   noc_tx_cmd,
  output logic         noc_tx_valid,
  input  logic         noc_tx_rdy,
  input  logic [63:0]  noc_rx_lo,
  input  logic [7:0]   noc_rx_cmd,
  input  logic         noc_rx_valid,
  output logic         noc_rx_rdy,
  output logic         busy,
  output logic         timeout,
  output logic [15:0]  blocks_done
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_IV, S_PT_LO, S_PT_HI, S_WAIT_LO, S_WAIT_HI, S_OUT
  } state_t;

  state_t         state_q, state_d;
  logic [63:0]    key_buf_q [KEY_WORDS];
  logic [127:0]   iv_q;
  logic [127:0]   pt_q, pt_d;
  logic [127:0]   ct_q, ct_d;
  logic [4:0]     beat_q, beat_d;
  logic           key_pend_q, key_pend_d;
  logic           iv_pend_q, iv_pend_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           timeout_q, timeout_d;
  logic [15:0]    blocks_q, blocks_d;
  logic           tx_fire, rsp_fire, in_wait, expire;

  assign tx_fire  = noc_tx_valid && noc_tx_rdy;
  assign rsp_fire = noc_rx_rdy && noc_rx_valid && (noc_rx_cmd == CMD_RSP);
  assign in_wait  = (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI);
  assign expire   = in_wait && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Key buffer and IV are host-owned storage and deliberately survive reset.
  always_ff @(posedge clk) begin
    if (key_wr_en && (key_wr_addr < 5'(KEY_WORDS))) key_buf_q[key_wr_addr] <= key_wr_data;
    if (iv_load) iv_q <= iv_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (key_pend_q)     state_d = S_KEY;
        else if (iv_pend_q) state_d = S_IV;
        else if (pt_valid)  state_d = S_PT_LO;
      end
      S_KEY:     if (tx_fire && (beat_q == 5'(KEY_WORDS - 1))) state_d = S_IDLE;
      S_IV:      if (tx_fire && beat_q[0]) state_d = S_IDLE;
      S_PT_LO:   if (tx_fire) state_d = S_PT_HI;
      S_PT_HI:   if (tx_fire) state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (expire)        state_d = S_IDLE;
        else if (rsp_fire) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (expire)        state_d = S_IDLE;
        else if (rsp_fire) state_d = S_OUT;
      end
      S_OUT:     if (ct_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // A load request arriving on the very cycle its sequence starts stays pending for a rerun.
  always_comb begin
    beat_d     = (state_q == S_IDLE) ? 5'd0 : (tx_fire ? beat_q + 5'd1 : beat_q);
    key_pend_d = key_load || (key_pend_q && (state_q != S_IDLE));
    iv_pend_d  = iv_load || (iv_pend_q && !((state_q == S_IDLE) && !key_pend_q));
    pt_d       = (pt_valid && pt_ready) ? pt_data : pt_q;
    timer_d    = in_wait ? timer_q + TW'(1) : '0;
    timeout_d  = timeout_q || expire;
    blocks_d   = blocks_q + 16'((state_q == S_OUT) && ct_ready);
    ct_d       = ct_q;
    if (rsp_fire && !expire) begin
      if (state_q == S_WAIT_LO) ct_d[63:0]   = noc_rx_lo;
      else                      ct_d[127:64] = noc_rx_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q     <= '0;
      key_pend_q <= 1'b0;
      iv_pend_q  <= 1'b0;
      pt_q       <= '0;
      ct_q       <= '0;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
      blocks_q   <= '0;
    end else begin
      beat_q     <= beat_d;
      key_pend_q <= key_pend_d;
      iv_pend_q  <= iv_pend_d;
      pt_q       <= pt_d;
      ct_q       <= ct_d;
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
      blocks_q   <= blocks_d;
    end
  end

  always_comb begin
    noc_tx_valid = 1'b0;
    noc_tx_cmd   = 8'd0;
    noc_tx_lo    = 64'd0;
    noc_rx_rdy   = 1'b0;
    ct_valid     = 1'b0;
    pt_ready     = 1'b0;
    case (state_q)
      S_IDLE:  pt_ready = !reset && !key_pend_q && !iv_pend_q;
      S_KEY: begin
        noc_tx_valid = 1'b1;
        noc_tx_cmd   = CMD_KEY;
        noc_tx_lo    = key_buf_q[beat_q];
      end
      S_IV: begin
        noc_tx_valid = 1'b1;
        noc_tx_cmd   = CMD_IV;
        noc_tx_lo    = beat_q[0] ? iv_q[127:64] : iv_q[63:0];
      end
      S_PT_LO: begin
        noc_tx_valid = 1'b1;
        noc_tx_cmd   = CMD_PT;
        noc_tx_lo    = pt_q[63:0];
      end
      S_PT_HI: begin
        noc_tx_valid = 1'b1;
        noc_tx_cmd   = CMD_PT;
        noc_tx_lo    = pt_q[127:64];
      end
      S_WAIT_LO, S_WAIT_HI: noc_rx_rdy = 1'b1;
      S_OUT:   ct_valid = 1'b1;
      default: ;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign ct_data     = ct_q;
  assign timeout     = timeout_q;
  assign blocks_done = blocks_q;

endmodule

// File: tb/tb_aes_noc_feeder.sv
// Directed-plus-random bench for aes_noc_feeder; expected beats and ciphertext come
// from a queue-based model of the link protocol kept here.
module tb_aes_noc_feeder;
  localparam int KEY_WORDS      = 22;
  localparam int TIMEOUT_CYCLES = 1023;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_wr_en;
  logic [4:0]   key_wr_addr;
  logic [63:0]  key_wr_data;
  logic         key_load;
  logic [127:0] iv_data;
  logic         iv_load;
  logic         pt_valid;
  logic         pt_ready;
  logic [127:0] pt_data;
  logic         ct_valid;
  logic         ct_ready;
  logic [127:0] ct_data;
  logic [63:0]  noc_tx_lo;
  logic [7:0]   noc_tx_cmd;
  logic         noc_tx_valid;
  logic         noc_tx_rdy;
  logic [63:0]  noc_rx_lo;
  logic [7:0]   noc_rx_cmd;
  logic         noc_rx_valid;
  logic         noc_rx_rdy;
  logic         busy;
  logic         timeout;
  logic [15:0]  blocks_done;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [71:0] txQ[$];
  logic [63:0] keyMem[KEY_WORDS];
  logic [15:0] expBlocks = 16'd0;
  bit          randRdy = 1'b0;
  bit          stallPending = 1'b0;
  logic [71:0] stallBeat = '0;

  aes_noc_feeder dut (
    .clk(clk), .reset(reset),
    .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr), .key_wr_data(key_wr_data),
    .key_load(key_load), .iv_data(iv_data), .iv_load(iv_load),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .noc_tx_lo(noc_tx_lo), .noc_tx_cmd(noc_tx_cmd), .noc_tx_valid(noc_tx_valid),
    .noc_tx_rdy(noc_tx_rdy),
    .noc_rx_lo(noc_rx_lo), .noc_rx_cmd(noc_rx_cmd), .noc_rx_valid(noc_rx_valid),
    .noc_rx_rdy(noc_rx_rdy),
    .busy(busy), .timeout(timeout), .blocks_done(blocks_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Link monitor: logs every transfer and insists a stalled beat is held unchanged.
  always @(negedge clk) begin
    if (reset) begin
      stallPending = 1'b0;
    end else begin
      if (stallPending)
        checkOutput("tx_stall_hold", 128'({noc_tx_valid, noc_tx_cmd, noc_tx_lo}),
                    128'({1'b1, stallBeat}));
      if (noc_tx_valid && noc_tx_rdy) txQ.push_back({noc_tx_cmd, noc_tx_lo});
      stallPending = noc_tx_valid && !noc_tx_rdy;
      stallBeat    = {noc_tx_cmd, noc_tx_lo};
    end
  end

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [71:0] txAt(input int idx);
    if (idx < txQ.size()) return txQ[idx];
    return {8'hEE, 64'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (randRdy) noc_tx_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic waitTx(input int target, input int budget, output int ptReadyCycles);
    int k = 0;
    ptReadyCycles = 0;
    while (txQ.size() < target && k < budget) begin
      if (pt_ready) ptReadyCycles++;
      tick();
      k++;
    end
    checkOutput("tx_beats_arrived", 128'(txQ.size() >= target), 128'(1));
  endtask

  task automatic writeKeys(input bit useRandom);
    for (int i = 0; i < KEY_WORDS; i++) begin
      keyMem[i]   = useRandom ? rnd64() : 64'h1000 + 64'(i);
      key_wr_en   = 1'b1;
      key_wr_addr = 5'(i);
      key_wr_data = keyMem[i];
      tick();
    end
    key_wr_addr = 5'd22 + 5'($urandom_range(0, 9));
    key_wr_data = '1;
    tick();
    key_wr_en = 1'b0;
  endtask

  task automatic checkKeyBeats(input int base);
    for (int i = 0; i < KEY_WORDS; i++)
      checkOutput("key_beat", 128'(txAt(base + i)), 128'({8'd0, keyMem[i]}));
  endtask

  task automatic sendPt(input logic [127:0] pt);
    int k = 0;
    int pr;
    int base = txQ.size();
    pt_data  = pt;
    pt_valid = 1'b1;
    while (!pt_ready && k < 100) begin
      tick();
      k++;
    end
    checkOutput("pt_ready_seen", 128'(pt_ready), 128'(1));
    tick();
    pt_valid = 1'b0;
    pt_data  = {rnd64(), rnd64()};
    waitTx(base + 2, 200, pr);
    checkOutput("pt_beat_lo", 128'(txAt(base)), 128'({8'd2, pt[63:0]}));
    checkOutput("pt_beat_hi", 128'(txAt(base + 1)), 128'({8'd2, pt[127:64]}));
  endtask

  task automatic applyStimulus(input logic [127:0] pt, input logic [63:0] lo,
                               input logic [63:0] hi, input bit stray,
                               input bit keyInWait, input int hold);
    ct_ready = (hold == 0);
    if (stray) begin
      noc_rx_valid = 1'b1;
      noc_rx_cmd   = 8'hFF;
      noc_rx_lo    = rnd64();
    end
    sendPt(pt);
    noc_rx_valid = 1'b0;
    checkOutput("wait_rx_rdy", 128'(noc_rx_rdy), 128'(1));
    if (keyInWait) begin
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
    end
    if (stray) begin
      noc_rx_valid = 1'b1;
      noc_rx_cmd   = 8'h02;
      noc_rx_lo    = rnd64();
      tick();
    end
    noc_rx_valid = 1'b1;
    noc_rx_cmd   = 8'hFF;
    noc_rx_lo    = lo;
    tick();
    noc_rx_lo = hi;
    tick();
    noc_rx_valid = 1'b0;
    noc_rx_lo    = rnd64();
    checkOutput("ct_valid_latency", 128'(ct_valid), 128'(1));
    checkOutput("ct_data", ct_data, {hi, lo});
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("ct_hold_valid", 128'(ct_valid), 128'(1));
      checkOutput("ct_hold_data", ct_data, {hi, lo});
    end
    ct_ready = 1'b1;
    tick();
    expBlocks++;
    checkOutput("ct_valid_drop", 128'(ct_valid), 128'(0));
    checkOutput("blocks_done", 128'(blocks_done), 128'(expBlocks));
  endtask

  task automatic runIv(input logic [127:0] iv);
    int pr;
    int base = txQ.size();
    iv_data = iv;
    iv_load = 1'b1;
    tick();
    iv_load = 1'b0;
    iv_data = {rnd64(), rnd64()};
    waitTx(base + 2, 200, pr);
    checkOutput("iv_beat_lo", 128'(txAt(base)), 128'({8'd1, iv[63:0]}));
    checkOutput("iv_beat_hi", 128'(txAt(base + 1)), 128'({8'd1, iv[127:64]}));
  endtask

  initial begin
    int base;
    int pr;
    int k;
    logic [127:0] ivVal;
    reset = 1'b1; key_wr_en = 0; key_wr_addr = 0; key_wr_data = 0; key_load = 0;
    iv_data = 0; iv_load = 0; pt_valid = 0; pt_data = 0; ct_ready = 1;
    noc_tx_rdy = 1; noc_rx_lo = 0; noc_rx_cmd = 0; noc_rx_valid = 0;
    repeat (3) tick();
    checkOutput("rst_tx_valid", 128'(noc_tx_valid), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_ct_valid", 128'(ct_valid), 128'(0));
    checkOutput("rst_ct_data", ct_data, 128'(0));
    checkOutput("rst_timeout", 128'(timeout), 128'(0));
    checkOutput("rst_blocks", 128'(blocks_done), 128'(0));
    checkOutput("rst_rx_rdy", 128'(noc_rx_rdy), 128'(0));
    checkOutput("rst_pt_ready", 128'(pt_ready), 128'(0));
    reset = 1'b0;
    tick();
    checkOutput("idle_pt_ready", 128'(pt_ready), 128'(1));

    // Key stream with known words, link always ready.
    writeKeys(1'b0);
    base = txQ.size();
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    waitTx(base + KEY_WORDS, 200, pr);
    checkKeyBeats(base);
    checkOutput("key_done_busy", 128'(busy), 128'(0));
    repeat (3) tick();
    checkOutput("key_no_extra", 128'(txQ.size()), 128'(base + KEY_WORDS));

    // IV with a stalled second beat.
    ivVal = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
    base = txQ.size();
    noc_tx_rdy = 1'b0;
    iv_data = ivVal;
    iv_load = 1'b1;
    tick();
    iv_load = 1'b0;
    iv_data = {rnd64(), rnd64()};
    tick();
    checkOutput("iv_first_valid", 128'({noc_tx_valid, noc_tx_cmd, noc_tx_lo}),
                128'({1'b1, 8'd1, ivVal[63:0]}));
    noc_tx_rdy = 1'b1;
    tick();
    noc_tx_rdy = 1'b0;
    checkOutput("iv_stall_a", 128'({noc_tx_valid, noc_tx_cmd, noc_tx_lo}),
                128'({1'b1, 8'd1, ivVal[127:64]}));
    tick();
    checkOutput("iv_stall_b", 128'({noc_tx_valid, noc_tx_cmd, noc_tx_lo}),
                128'({1'b1, 8'd1, ivVal[127:64]}));
    noc_tx_rdy = 1'b1;
    tick();
    checkOutput("iv_done_busy", 128'(busy), 128'(0));
    checkOutput("iv_beat_count", 128'(txQ.size()), 128'(base + 2));
    checkOutput("iv_beat_lo", 128'(txAt(base)), 128'({8'd1, ivVal[63:0]}));
    checkOutput("iv_beat_hi", 128'(txAt(base + 1)), 128'({8'd1, ivVal[127:64]}));

    // Directed plaintext block.
    applyStimulus(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, rnd64(), rnd64(), 0, 0, 0);

    // Key reload requested while waiting: block completes first, then the key stream.
    writeKeys(1'b1);
    applyStimulus({rnd64(), rnd64()}, rnd64(), rnd64(), 0, 1, 2);
    base = txQ.size();
    waitTx(base + KEY_WORDS, 200, pr);
    checkOutput("pt_ready_blocked_by_key", 128'(pr), 128'(0));
    checkKeyBeats(base);
    checkOutput("after_key_pt_ready", 128'(pt_ready), 128'(1));

    // Stray beats outside WAIT and a non-response beat inside WAIT_LO.
    applyStimulus({rnd64(), rnd64()}, rnd64(), rnd64(), 1, 0, 0);

    // Random traffic with a jittery link.
    randRdy = 1'b1;
    for (int i = 0; i < 5; i++)
      applyStimulus({rnd64(), rnd64()}, rnd64(), rnd64(), 1'($urandom_range(0, 1)), 0,
                    int'($urandom_range(0, 3)));
    runIv({rnd64(), rnd64()});
    randRdy = 1'b0;
    noc_tx_rdy = 1'b1;

    // No response: timeout abort.
    sendPt({rnd64(), rnd64()});
    checkOutput("timeout_before", 128'(timeout), 128'(0));
    k = 0;
    while (busy && k < 1200) begin
      tick();
      k++;
    end
    checkOutput("timeout_cycles", 128'(k), 128'(TIMEOUT_CYCLES));
    checkOutput("timeout_flag", 128'(timeout), 128'(1));
    checkOutput("timeout_pt_ready", 128'(pt_ready), 128'(1));
    checkOutput("timeout_blocks", 128'(blocks_done), 128'(expBlocks));
    checkOutput("timeout_ct_valid", 128'(ct_valid), 128'(0));
    applyStimulus({rnd64(), rnd64()}, rnd64(), rnd64(), 0, 0, 0);
    checkOutput("timeout_sticky", 128'(timeout), 128'(1));

    // Reset in the middle of the key stream.
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    repeat (5) tick();
    checkOutput("midkey_valid", 128'(noc_tx_valid), 128'(1));
    reset = 1'b1;
    tick();
    checkOutput("rst_mid_tx_valid", 128'(noc_tx_valid), 128'(0));
    checkOutput("rst_mid_busy", 128'(busy), 128'(0));
    checkOutput("rst_mid_timeout", 128'(timeout), 128'(0));
    checkOutput("rst_mid_blocks", 128'(blocks_done), 128'(0));
    reset = 1'b0;
    base = txQ.size();
    repeat (5) tick();
    checkOutput("rst_no_resume", 128'(txQ.size()), 128'(base));
    checkOutput("rst_idle", 128'(busy), 128'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/aes_noc_feeder.md
Name: aes_noc_feeder

Overview:
Host-side NOC16 driver that sits directly upstream of the AES-CBC peripheral and consumes its responses. It streams the expanded round key (22 beats, cmd 0), the IV (2 beats, cmd 1) and 128-bit plaintext blocks (2 beats, cmd 2) onto the NOC16 link. It then reassembles the two-beat ciphertext response (cmd 8'hFF) into a 128-bit output with valid/ready flow control. Only one block is outstanding at a time, matching the single-block peripheral.

Parameters:
KEY_WORDS, 22, number of 64-bit round-key beats (176 bytes).
CMD_KEY, 8'd0, command code for round-key beats.
CMD_IV, 8'd1, command code for IV beats.
CMD_PT, 8'd2, command code for plaintext beats.
CMD_RSP, 8'hFF, command code of response beats.
TIMEOUT_CYCLES, 1023, maximum cycles spent in a WAIT state before aborting.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
key_wr_en  in  1  write one round-key word into the internal buffer
key_wr_addr  in  5  word index 0..KEY_WORDS-1; writes at or above KEY_WORDS are ignored
key_wr_data  in  64  round-key word; word 0 = rk[63:0]
key_load  in  1  pulse: request transmission of the key buffer
iv_data  in  128  IV value, sampled on iv_load
iv_load  in  1  pulse: latch iv_data and request IV transmission
pt_valid / pt_ready  in / out  1 / 1  plaintext handshake
pt_data  in  128  plaintext block
ct_valid / ct_ready  out / in  1 / 1  ciphertext handshake
ct_data  out  128  ciphertext block; response beat 0 goes to [63:0], beat 1 to [127:64]
noc_tx_lo / noc_tx_cmd / noc_tx_valid  out  64 / 8 / 1  NOC16 transmit
noc_tx_rdy  in  1  NOC16 transmit ready
noc_rx_lo / noc_rx_cmd / noc_rx_valid  in  64 / 8 / 1  NOC16 receive
noc_rx_rdy  out  1  NOC16 receive ready
busy  out  1  high in any state other than IDLE
timeout  out  1  sticky flag; cleared only by reset
blocks_done  out  16  count of completed ciphertext handoffs; wraps at 16 bits

Behaviour:
- Reset values: all outputs 0, state IDLE, pending flags 0, timer 0. The key buffer and IV register are not reset.
- Tx beat transfer: occurs on a cycle where noc_tx_valid && noc_tx_rdy.
  - noc_tx_lo/cmd stay stable while valid && !rdy.
  - noc_tx_valid may be high in back-to-back cycles.
- Rx beat acceptance: noc_rx_rdy = 1 exactly in the WAIT_LO and WAIT_HI states. The downstream peripheral ignores rdy, so any beat arriving in another state is dropped.
- Pending flags: key_load and iv_load each set a pending flag in any state. The flag clears when the corresponding sequence leaves IDLE.
- iv_load also latches iv_data in the same cycle. If iv_load asserts during the IV state, the beats still to be sent use the new value.
- IDLE: priority is key_pend > iv_pend > pt_valid. pt_ready = 1 only in IDLE when neither flag is pending. A pt handshake latches pt_data and moves to PT_LO.
- KEY: sends words 0..KEY_WORDS-1 with CMD_KEY, one per transfer, using a 5-bit index. Returns to IDLE after the last transfer.
- IV: sends iv[63:0], then iv[127:64], with CMD_IV. Returns to IDLE after the second transfer.
- PT_LO, PT_HI: send pt[63:0], then pt[127:64], with CMD_PT. Go to WAIT_LO after the PT_HI transfer.
- WAIT_LO:
  - A beat with cmd==CMD_RSP is stored in ct_data[63:0] and the state moves to WAIT_HI.
  - A beat with any other cmd is dropped and the state does not change.
- WAIT_HI: a CMD_RSP beat is stored in ct_data[127:64] and the state moves to OUT.
- OUT: ct_valid = 1 and ct_data is held until ct_ready. On the handshake: ct_valid drops the next cycle, blocks_done increments, state returns to IDLE.
- Minimum latency is one cycle from the second response beat to ct_valid.
- Timeout: the timer resets on entering WAIT_LO and counts every WAIT cycle. When it reaches TIMEOUT_CYCLES: timeout is set, the partial result is discarded, the state returns to IDLE, and blocks_done is unchanged.
- The IV is never resent automatically; the peripheral chains its own IV. Key/IV reloads are never interleaved inside a PT/WAIT/OUT sequence; they wait for IDLE.
- Reset mid-sequence: aborts immediately and all outputs return to reset values. The host must reissue key_load/iv_load.

Test Plan:
1. Write key words k[i]=64'h1000+i for i=0..21, pulse key_load, hold noc_tx_rdy=1 -> exactly 22 beats with cmd 0, data 64'h1000..64'h1015 in order, then busy=0.
2. iv_load with 128'hAAAA_..._5555, then noc_tx_rdy toggles 1,0,1 -> beats 64'h..5555 then 64'hAAAA.., cmd 1, data stable during the stall.
3. pt_data=128'h0011..EEFF, response beats 64'hL then 64'hH with cmd FF, ct_ready=1 -> ct_data={H,L}, one ct_valid cycle, blocks_done=1.
4. key_load pulsed in WAIT_LO -> response accepted, ct delivered, then the 22-beat key sequence starts. pt_ready stays 0 until the key sequence finishes.
5. In WAIT_LO, beat with cmd 8'h02, then cmd FF, FF -> stray beat ignored, ct_data assembled from the two FF beats only.
6. No response for TIMEOUT_CYCLES -> timeout=1, state IDLE, pt_ready=1, blocks_done unchanged. Then assert reset mid-KEY -> noc_tx_valid=0 the next cycle.
